// File: rtl/nn_dense_neuron_if.sv
// Stream bundle for the dense neuron: x/w beats in, 8-bit result out.
// The master side drives beats and accepts results; the slave side is the neuron.
interface nn_dense_neuron_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] w;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid, x, w, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, x, w, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/nn_dense_neuron.sv
// Single-neuron MAC: bias load, N_INPUTS x*w beats, shift, saturate.
// Define NN_DENSE_RELU_EN to clamp negative results to zero (range 0..127).
module nn_dense_neuron #(
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         bias,
    input  logic                abort,
    output logic                busy,
    nn_dense_neuron_if.slave    io
);
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESULT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [16:0]      prod;
    logic [CNT_W-1:0]        count;
    logic [7:0]              result;
    logic                    beat;
    logic                    last;

    assign beat = io.in_valid && (state == ACCUM);
    assign last = (count == LAST);
    assign busy = (state != IDLE);

    // Product of unsigned activation and signed weight, then the post-processed result
    always_comb begin
        prod    = 17'($signed({1'b0, io.x})) * 17'($signed(io.w));
        sum     = acc + {{(ACC_W-17){prod[16]}}, prod};
        shifted = sum >>> SHIFT;
        result  = shifted[7:0];
`ifdef NN_DENSE_RELU_EN
        if (shifted[ACC_W-1]) begin
            result = 8'h00;
        end else if (shifted > SAT_HI) begin
            result = 8'h7F;
        end
`else
        if (shifted > SAT_HI) begin
            result = 8'h7F;
        end else if (shifted < SAT_LO) begin
            result = 8'h80;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; abort wins over everything else
    always_comb begin
        state_next   = state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                io.in_ready = 1'b1;
                if (beat && last) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                io.out_valid = 1'b1;
                if (io.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Accumulator, beat counter and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            count       <= '0;
            io.out_data <= 8'h00;
        end else if (abort) begin
            acc   <= '0;
            count <= '0;
        end else if (state == IDLE && start) begin
            acc   <= {{(ACC_W-16){bias[15]}}, bias};
            count <= '0;
        end else if (beat) begin
            acc   <= sum;
            count <= count + 1'b1;
            if (last) begin
                io.out_data <= result;
            end
        end
    end
endmodule

// File: tb/tb_nn_dense_neuron.sv
// Directed bench for nn_dense_neuron (N_INPUTS=4; SHIFT=0 and SHIFT=2 instances).
// Expected values follow the NN_DENSE_RELU_EN setting of the build.
module tb_nn_dense_neuron;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic        abort_a = 1'b0;
    logic [15:0] bias_a = 16'h0;
    logic        busy_a;
    logic        start_b = 1'b0;
    logic        abort_b = 1'b0;
    logic [15:0] bias_b = 16'h0;
    logic        busy_b;

    nn_dense_neuron_if bus_a ();
    nn_dense_neuron_if bus_b ();

    nn_dense_neuron #(.N_INPUTS(4), .ACC_W(24), .SHIFT(0)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .bias  (bias_a),
        .abort (abort_a),
        .busy  (busy_a),
        .io    (bus_a)
    );

    nn_dense_neuron #(.N_INPUTS(4), .ACC_W(24), .SHIFT(2)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_b),
        .bias  (bias_b),
        .abort (abort_b),
        .busy  (busy_b),
        .io    (bus_b)
    );

`ifdef NN_DENSE_RELU_EN
    localparam logic [7:0] EXP_MIN   = 8'h00;
    localparam logic [7:0] EXP_NEG   = 8'h00;
    localparam logic [7:0] EXP_SHIFT = 8'h00;
`else
    localparam logic [7:0] EXP_MIN   = 8'h80;
    localparam logic [7:0] EXP_NEG   = 8'hD8;
    localparam logic [7:0] EXP_SHIFT = 8'hFE;
`endif

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_a(input logic [15:0] b);
        start_a = 1'b1;
        bias_a  = b;
        step();
        start_a = 1'b0;
    endtask

    task automatic feed_a(input logic [7:0] xv, input logic [7:0] xinc,
                          input logic [7:0] wv, input int gap);
        for (int i = 0; i < 4; i++) begin
            bus_a.x        = xv + 8'(i) * xinc;
            bus_a.w        = wv;
            bus_a.in_valid = 1'b1;
            step();
            bus_a.in_valid = 1'b0;
            bus_a.x        = 8'd99;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) step();
            end
        end
    endtask

    task automatic retire_a();
        bus_a.out_ready = 1'b1;
        step();
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus_a.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", bus_a.in_ready);
        end
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus_a.out_valid);
        end
        checks++;
        if (bus_a.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_data: got %h want 00", bus_a.out_data);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy_a);
        end
    endtask

    task automatic test_back_to_back();
        begin_a(16'd10);
        checks++;
        if (busy_a !== 1'b1 || bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accum: busy=%b in_ready=%b want 1 1",
                     busy_a, bus_a.in_ready);
        end
        feed_a(8'd1, 8'd1, 8'd1, 0);
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h14) begin
            errors++;
            $display("FAIL b2b_result: valid=%b data=%h want 1 14",
                     bus_a.out_valid, bus_a.out_data);
        end
        retire_a();
        checks++;
        if (bus_a.out_valid !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_retire: valid=%b busy=%b want 0 0",
                     bus_a.out_valid, busy_a);
        end
        checks++;
        if (bus_a.out_data !== 8'h14) begin
            errors++;
            $display("FAIL b2b_hold: got %h want 14", bus_a.out_data);
        end
    endtask

    task automatic test_saturation();
        begin_a(16'd0);
        feed_a(8'd255, 8'd0, 8'd127, 0);
        checks++;
        if (bus_a.out_data !== 8'h7F) begin
            errors++;
            $display("FAIL sat_high: got %h want 7f", bus_a.out_data);
        end
        retire_a();
        begin_a(16'd0);
        feed_a(8'd255, 8'd0, 8'h80, 0);
        checks++;
        if (bus_a.out_data !== EXP_MIN) begin
            errors++;
            $display("FAIL sat_low: got %h want %h", bus_a.out_data, EXP_MIN);
        end
        retire_a();
    endtask

    task automatic test_negative();
        begin_a(16'd0);
        feed_a(8'd10, 8'd0, 8'hFF, 0);
        checks++;
        if (bus_a.out_data !== EXP_NEG) begin
            errors++;
            $display("FAIL negative: got %h want %h", bus_a.out_data, EXP_NEG);
        end
        retire_a();
    endtask

    task automatic test_shift();
        start_b = 1'b1;
        bias_b  = 16'hFFFB;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_b.x        = 8'd0;
            bus_b.w        = 8'd0;
            bus_b.in_valid = 1'b1;
            step();
        end
        bus_b.in_valid = 1'b0;
        checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== EXP_SHIFT) begin
            errors++;
            $display("FAIL shift: valid=%b data=%h want 1 %h",
                     bus_b.out_valid, bus_b.out_data, EXP_SHIFT);
        end
        bus_b.out_ready = 1'b1;
        step();
        bus_b.out_ready = 1'b0;
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL shift_retire: busy=%b want 0", busy_b);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        begin_a(16'd10);
        feed_a(8'd1, 8'd1, 8'd1, 0);
        for (int i = 0; i < 5; i++) begin
            start_a        = (i % 2 == 0);
            bus_a.in_valid = (i % 2 == 1);
            bus_a.x        = 8'd200;
            bus_a.w        = 8'd100;
            step();
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h14 ||
                bus_a.in_ready !== 1'b0) bad++;
        end
        start_a        = 1'b0;
        bus_a.in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d bad cycles want 0", bad);
        end
        retire_a();
        checks++;
        if (bus_a.out_valid !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_retire: valid=%b busy=%b want 0 0",
                     bus_a.out_valid, busy_a);
        end
    endtask

    task automatic test_gapped();
        begin_a(16'd10);
        feed_a(8'd1, 8'd1, 8'd1, 2);
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h14) begin
            errors++;
            $display("FAIL gapped: valid=%b data=%h want 1 14",
                     bus_a.out_valid, bus_a.out_data);
        end
        retire_a();
    endtask

    task automatic test_abort();
        abort_a = 1'b1;
        start_a = 1'b1;
        step();
        abort_a = 1'b0;
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_over_start: busy=%b want 0", busy_a);
        end
        begin_a(16'd10);
        bus_a.x        = 8'd1;
        bus_a.w        = 8'd1;
        bus_a.in_valid = 1'b1;
        step();
        step();
        abort_a = 1'b1;
        step();
        abort_a        = 1'b0;
        bus_a.in_valid = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || bus_a.in_ready !== 1'b0 ||
            bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b in_ready=%b valid=%b want 0 0 0",
                     busy_a, bus_a.in_ready, bus_a.out_valid);
        end
        begin_a(16'd0);
        feed_a(8'd1, 8'd0, 8'd1, 0);
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h04) begin
            errors++;
            $display("FAIL abort_restart: valid=%b data=%h want 1 04",
                     bus_a.out_valid, bus_a.out_data);
        end
        retire_a();
    endtask

    task automatic test_async_reset();
        begin_a(16'd5);
        bus_a.x        = 8'd3;
        bus_a.w        = 8'd3;
        bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || bus_a.in_ready !== 1'b0 ||
            bus_a.out_valid !== 1'b0 || bus_a.out_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: busy=%b rdy=%b vld=%b data=%h want 0 0 0 00",
                     busy_a, bus_a.in_ready, bus_a.out_valid, bus_a.out_data);
        end
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_idle: busy=%b want 0", busy_a);
        end
    endtask

    initial begin
        bus_a.in_valid  = 1'b0;
        bus_a.x         = 8'd0;
        bus_a.w         = 8'd0;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.x         = 8'd0;
        bus_b.w         = 8'd0;
        bus_b.out_ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_back_to_back();
        test_saturation();
        test_negative();
        test_shift();
        test_backpressure();
        test_gapped();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nn_dense_neuron.md
Name: nn_dense_neuron

Overview:
Single-neuron multiply-accumulate engine for the MNIST accelerator. It is the compute stage directly downstream of the top-level pin interface: the top sequences activations and weights from ui_in/uio_in into this block, and presents the 8-bit result back on uo_out. One operation is: load a bias, accumulate N_INPUTS activation×weight products, then shift, saturate and optionally ReLU the result. Output uses a valid/ready handshake.

Parameters:
N_INPUTS, 16, number of (x,w) beats per neuron evaluation; must be ≥1.
ACC_W, 24, signed accumulator width; must be ≥ 18+clog2(N_INPUTS).
SHIFT, 6, arithmetic right shift applied to the accumulator before saturation; 0..ACC_W-1.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin an evaluation; sampled only in IDLE
bias  in  16  signed bias, captured with start
abort  in  1  synchronous clear to IDLE from any state
in_valid  in  1  x/w beat valid
in_ready  out  1  block accepts a beat
x  in  8  unsigned activation
w  in  8  signed two's-complement weight
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  8  result (signed, or 0..127 with ReLU)
busy  out  1  high in ACCUM or RESULT

Behaviour:
- Clocking/reset: single clock clk; reset rst_n asynchronous, active-low. On reset: state=IDLE, accumulator=0, beat counter=0, in_ready=0, out_valid=0, out_data=0, busy=0.
- States: IDLE, ACCUM, RESULT.
- IDLE: in_ready=0, out_valid=0. start=1 → acc ← sign-extended bias, count ← 0, go ACCUM next cycle.
- ACCUM: in_ready=1. Beat accepted when in_valid&in_ready. Per beat: acc ← acc + ($signed({1'b0,x}) × $signed(w)), product is 17-bit signed, sign-extended to ACC_W. count increments; beat with count==N_INPUTS-1 is last.
- Last beat accepted → next cycle state=RESULT, out_valid=1, out_data registered from final acc (includes last product). Latency: 1 cycle from last beat to out_valid.
- Post-processing: s = acc >>> SHIFT (arithmetic, truncates toward −inf). Saturate s to [-128,127].
- RESULT: out_valid=1, in_ready=0; out_data stable while out_valid&!out_ready. out_valid&out_ready → IDLE next cycle, out_valid=0. start in RESULT ignored. out_data holds last value after leaving RESULT.
- start while in ACCUM/RESULT ignored (no restart).
- abort=1: next cycle IDLE, acc=0, count=0, out_valid=0, in_ready=0; abort has priority over start, beats and out_ready in the same cycle. Any partial result discarded.
- in_valid with in_ready=0: ignored, no state change.
- Accumulator never overflows within parameter limits; no wrap handling required beyond the ACC_W constraint.
- busy = (state != IDLE).

Optional Feature:
Macro NN_DENSE_RELU_EN. Defined: after shift, negative s → out_data=0; positive saturates at 127 (range 0..127). Not defined: out_data is signed saturation of s to [-128,127] (e.g. -40 → 8'hD8). Handshake and timing identical in both builds.

Test Plan:
N_INPUTS=4, SHIFT=0, bias=10, x=1,2,3,4, w=1,1,1,1 back-to-back → out_valid 1 cycle after 4th beat, out_data=20 (0x14), busy drops after out_ready.
N_INPUTS=4, SHIFT=0, bias=0, x=255 ×4, w=127 ×4 (acc=129540) → out_data=127; w=-128 ×4 (acc=-130560) → out_data=0x80 (0 with NN_DENSE_RELU_EN).
N_INPUTS=4, SHIFT=0, bias=0, x=10 ×4, w=-1 ×4 → out_data=0xD8 without macro, 0x00 with NN_DENSE_RELU_EN; N=4, SHIFT=2, bias=0, x=1, w=-1 ×4... acc=-4... verify shift: bias=-5, no beats product → acc=-5>>>2 = -2 (0xFE).
Backpressure: hold out_ready=0 for 5 cycles in RESULT, toggle start and in_valid → out_valid and out_data constant, no new beats accepted; out_ready=1 → IDLE next cycle.
Gapped input: in_valid toggled 1,0,0,1,... across 4 beats → result equals back-to-back case (20).
abort after 2 beats, then fresh start with bias=0, x=1,w=1 ×4 → out_data=4; rst_n pulsed low mid-ACCUM → all outputs 0 immediately (asynchronously), state IDLE.
